// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 key-scheduling shuffle.
// Contents: byte_t, shuffle_state_e, KEY_BYTES (default key length), ARRAY_LAST (last S index).
package rc4_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_I,
      S_WT_I,
      S_RD_J,
      S_WT_J,
      S_WR_I,
      S_WR_J,
      S_DONE
   } shuffle_state_e;
   localparam int KEY_BYTES = 3;
   localparam byte_t ARRAY_LAST = 8'hFF;
endpackage

// File: rtl/rc4_key_sel.sv
// rc4_key_sel: picks key byte number sel_i from a packed key whose byte 0 sits in the MSBs.
// Ports: sel_i (i mod KEY_BYTES), key_i (latched key), byte_o (selected key byte).
module rc4_key_sel #(
   parameter int KEY_BYTES = 3,
   parameter int SW = 2
) (
   input  logic [SW-1:0]          sel_i,
   input  logic [8*KEY_BYTES-1:0] key_i,
   output logic [7:0]             byte_o
);
   always_comb begin
      byte_o = '0;
      for (int n = 0; n < KEY_BYTES; n++)
         if (sel_i == SW'(n)) byte_o = key_i[8*(KEY_BYTES-1-n) +: 8];
   end
endmodule

// File: rtl/rc4_shuffle_array.sv
// rc4_shuffle_array: RC4 key-scheduling swap pass over an external 256-byte S RAM.
// Ports: clk, rst (synchronous, active-high), start (level, sampled in IDLE only),
//   secret_key (byte 0 in the MSBs), data_in (RAM read data, one cycle after the address),
//   data_out / address_out / is_write (RAM port), shuffle_finish (high in DONE until start drops).
// Option: define SHUFFLE_SKIP_SELF_SWAP_EN to skip the s[j] read and both writes when j==i.
module rc4_shuffle_array #(
   parameter int KEY_BYTES  = 3,
   parameter int RAM_RD_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   output logic [7:0]             address_out,
   output logic                   is_write,
   output logic                   shuffle_finish
);
   import rc4_pkg::*;

   localparam int SW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

   if (RAM_RD_LAT != 1) begin : g_lat_check
      $error("rc4_shuffle_array supports RAM_RD_LAT=1 only");
   end

   shuffle_state_e         state_q;
   byte_t                  i_q, j_q, si_q, sj_q, addr_q, data_q, j_d, key_byte;
   logic                   we_q, fin_q, skip_self, advance;
   logic [8*KEY_BYTES-1:0] key_q;
   logic [SW-1:0]          kidx_q, kidx_d;

   rc4_key_sel #(.KEY_BYTES(KEY_BYTES), .SW(SW)) u_key_sel (
      .sel_i  (kidx_q),
      .key_i  (key_q),
      .byte_o (key_byte)
   );

   assign j_d    = j_q + data_in + key_byte;
   assign kidx_d = (kidx_q == SW'(KEY_BYTES-1)) ? '0 : kidx_q + 1'b1;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
   assign skip_self = (state_q == S_WT_I) && (j_d == i_q);
`else
   assign skip_self = 1'b0;
`endif
   // End of an iteration: either the second write, or a self-swap that needs no RAM traffic.
   assign advance = (state_q == S_WR_J) || skip_self;

   // Outputs are loaded on the transition into the state that presents them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         fin_q   <= 1'b0;
         key_q   <= '0;
         kidx_q  <= '0;
      end else if (advance) begin
         we_q <= 1'b0;
         if (state_q == S_WT_I) begin
            si_q <= data_in;
            j_q  <= j_d;
         end
         if (i_q == ARRAY_LAST) begin
            state_q <= S_DONE;
            fin_q   <= 1'b1;
            addr_q  <= '0;
         end else begin
            state_q <= S_RD_I;
            i_q     <= i_q + 8'd1;
            kidx_q  <= kidx_d;
            addr_q  <= i_q + 8'd1;
         end
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               key_q   <= secret_key;
               i_q     <= '0;
               j_q     <= '0;
               kidx_q  <= '0;
               addr_q  <= '0;
               state_q <= S_RD_I;
            end
            S_RD_I: state_q <= S_WT_I;
            S_WT_I: begin
               si_q    <= data_in;
               j_q     <= j_d;
               addr_q  <= j_d;
               state_q <= S_RD_J;
            end
            S_RD_J: state_q <= S_WT_J;
            S_WT_J: begin
               sj_q    <= data_in;
               addr_q  <= i_q;
               data_q  <= data_in;
               we_q    <= 1'b1;
               state_q <= S_WR_I;
            end
            S_WR_I: begin
               addr_q  <= j_q;
               data_q  <= si_q;
               state_q <= S_WR_J;
            end
            S_DONE: if (!start) begin
               fin_q   <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign address_out    = addr_q;
   assign data_out       = data_q;
   assign is_write       = we_q;
   assign shuffle_finish = fin_q;
endmodule

// File: tb/tb_rc4_shuffle_array.sv
// tb_rc4_shuffle_array: scoreboard bench for rc4_shuffle_array with a 1-cycle-latency RAM model.
module tb_rc4_shuffle_array;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [23:0] secret_key = '0;
   logic [7:0]  data_in, data_out, address_out;
   logic        is_write, shuffle_finish;

   logic [7:0]  mem [256];
   logic [7:0]  rd_q;
   logic        ram_init = 1'b0;

   logic [15:0] exp_q [$];
   logic [15:0] hand_w [$];
   int          checks = 0;
   int          passes = 0;
   int          wcount = 0;

   rc4_shuffle_array dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .secret_key     (secret_key),
      .data_in        (data_in),
      .data_out       (data_out),
      .address_out    (address_out),
      .is_write       (is_write),
      .shuffle_finish (shuffle_finish)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_init) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (is_write) begin
         mem[address_out] <= data_out;
      end
      rd_q <= mem[address_out];
   end
   assign data_in = rd_q;

   // Monitor: every RAM write the DUT presents is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (!rst && is_write) begin
         wcount++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL write_unexpected: got addr=%02h data=%02h, required no write", address_out, data_out);
         end else begin
            automatic logic [15:0] e = exp_q.pop_front();
            if ({address_out, data_out} !== e)
               $display("FAIL write_value: got addr=%02h data=%02h, required addr=%02h data=%02h",
                        address_out, data_out, e[15:8], e[7:0]);
            else passes++;
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got !== want) $display("FAIL %s: got %0d, required %0d", name, got, want);
      else passes++;
   endtask

   task automatic init_ram();
      @(negedge clk);
      ram_init = 1'b1;
      @(negedge clk);
      ram_init = 1'b0;
   endtask

   // Software KSA reference; the first hand_w entries replace the model's early writes.
   task automatic run_pass(input logic [23:0] key, input int hand_iters, input bit change_key);
      logic [7:0] s [256];
      logic [7:0] j, t, kb;
      int cyc, nwr, n, bad;
      for (int k = 0; k < 256; k++) s[k] = 8'(k);
      j = 0; cyc = 0; nwr = 0;
      while (hand_w.size() > 0) begin
         exp_q.push_back(hand_w.pop_front());
      end
      for (int i = 0; i < 256; i++) begin
         kb = 8'(key >> (8 * (2 - (i % 3))));
         j = j + s[i] + kb;
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
         if (j == 8'(i)) begin
            cyc += 2;
            continue;
         end
`endif
         if (i >= hand_iters) begin
            exp_q.push_back({8'(i), s[j]});
            exp_q.push_back({j, s[i]});
         end
         nwr += 2;
         cyc += 6;
         t = s[i]; s[i] = s[j]; s[j] = t;
      end
      init_ram();
      wcount = 0;
      secret_key = key;
      start = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (change_key && n == 100) secret_key = ~key;
      end while (!shuffle_finish && n < 5000);
      check("finish_latency", n, cyc + 1);
      check("write_count", wcount, nwr);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      bad = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== s[k]) bad++;
      check("ram_vs_reference_mismatches", bad, 0);
      bad = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (!shuffle_finish || is_write || address_out != 0) bad++;
      end
      check("done_hold_bad_cycles", bad, 0);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("finish_drop", int'(shuffle_finish), 0);
      secret_key = key;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      init_ram();
      repeat (3) @(posedge clk);
      #1;
      check("reset_is_write", int'(is_write), 0);
      check("reset_address", int'(address_out), 0);
      check("reset_finish", int'(shuffle_finish), 0);
      rst = 1'b0;

      // Abort mid-pass in WR_I of i=0.
      exp_q.push_back({8'h00, 8'h12});
      secret_key = 24'h123456;
      @(negedge clk);
      start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!is_write && n < 50);
      check("abort_reached_write", int'(n < 50), 1);
      #1;
      rst = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("abort_is_write", int'(is_write), 0);
      check("abort_address", int'(address_out), 0);
      check("abort_finish", int'(shuffle_finish), 0);
      check("abort_queue", exp_q.size(), 0);
      exp_q.delete();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Key 123456: first three iterations hand-computed.
      hand_w = '{16'h0012, 16'h1200, 16'h0147, 16'h4701, 16'h029F, 16'h9F02};
      run_pass(24'h123456, 3, 1'b0);

      // Key 000000: i=0 and i=1 are self-swaps, i=2 swaps s[2] and s[3].
`ifdef SHUFFLE_SKIP_SELF_SWAP_EN
      hand_w = '{16'h0203, 16'h0302};
`else
      hand_w = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
`endif
      run_pass(24'h000000, 3, 1'b0);

      // Key changed mid-pass must not affect the result.
      hand_w = '{16'h0012, 16'h1200, 16'h0147, 16'h4701, 16'h029F, 16'h9F02};
      run_pass(24'h123456, 3, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
